fetch_controller: RTL
=====================

// Module: fetch_controller
// PURPOSE
//   Sequences instruction fetch into the instruction buffer. Generates sequential fetch
//   addresses, issues requests to instruction memory under a credit scheme so that every
//   returning instruction is guaranteed a free buffer slot, and writes responses into the buffer.
//   On a redirect it flushes the buffer, drops stale in-flight responses and restarts at the new PC.
// PARAMETERS
//   INST_WIDTH       32          instruction width, equal to the instruction buffer width
//   ADDR_WIDTH       32          fetch address width
//   BUFFER_DEPTH     8           depth of the instruction buffer being fed (>=2, power of two)
//   MAX_OUTSTANDING  4           maximum number of unanswered imem requests (>=1)
//   RESET_PC         32'h0       first fetch address after reset
// PORTS
//   clk              in   1           clock
//   reset            in   1           asynchronous, active-low reset (0 = reset asserted)
//   fetch_en         in   1           1 = issue new fetch requests
//   redirect_valid   in   1           1-cycle pulse: discard the current stream, restart at redirect_pc
//   redirect_pc      in   ADDR_WIDTH  new fetch address, word aligned
//   imem_req_valid   out  1           fetch request valid
//   imem_req_addr    out  ADDR_WIDTH  fetch address (= pc)
//   imem_req_ready   in   1           imem accepts the request this cycle
//   imem_resp_valid  in   1           instruction returned; in order, one per accepted request
//   imem_resp_data   in   INST_WIDTH  returned instruction
//   buf_wr_en        out  1           write strobe into the instruction buffer
//   buf_wr_data      out  INST_WIDTH  data written into the instruction buffer (= imem_resp_data)
//   buf_rd_en        in   1           the buffer consumer popped one valid entry this cycle
//   buf_flush        out  1           1-cycle pulse: clear the buffer pointers
//   busy             out  1           state != IDLE
//   proto_err        out  1           sticky: a response arrived with outstanding == 0
// BEHAVIOUR
//   Reset (async, reset==0): state=IDLE, pc=RESET_PC, credits=BUFFER_DEPTH, outstanding=0,
//     drop_cnt=0, proto_err=0. All outputs are 0 except imem_req_addr, which is RESET_PC.
//   Counters:
//     credits: width $clog2(BUFFER_DEPTH+1). Counts free slots minus slots reserved by in-flight requests.
//     outstanding: width $clog2(MAX_OUTSTANDING+1).
//     Neither counter wraps. Underflow or overflow is a design error; the verifier asserts against it.
//   Request issue:
//     req_fire = imem_req_valid & imem_req_ready.
//     imem_req_valid = (state==FETCH) & fetch_en & !redirect_valid & credits!=0 & outstanding<MAX_OUTSTANDING.
//       It is combinational; imem tolerates withdrawal of valid.
//     On req_fire: pc += 4 (wraps modulo 2^ADDR_WIDTH), credits -= 1, outstanding += 1.
//   Response:
//     Every imem_resp_valid decrements outstanding.
//     If drop_cnt==0 and no redirect is active this cycle: buf_wr_en=1, buf_wr_data=imem_resp_data,
//       same cycle (0 latency).
//     Otherwise the response is dropped: buf_wr_en=0, drop_cnt -= 1 if drop_cnt!=0, credits += 1.
//     imem_resp_valid with outstanding==0: response is ignored, proto_err is set.
//     proto_err is cleared only by reset.
//   Pop: buf_rd_en increments credits, except in a redirect cycle.
//   Concurrent req_fire, response and pop in one cycle: all net deltas apply together.
//     Example: +1 (pop) - 1 (issue) leaves credits unchanged.
//   Redirect (redirect_valid=1, any state except IDLE):
//     buf_flush=1 this cycle. pc <= redirect_pc. No request is issued this cycle.
//     Any response this cycle is dropped.
//     Let o_next = outstanding after this cycle's response.
//       drop_cnt <= o_next; credits <= BUFFER_DEPTH - o_next.
//     Next state: DRAIN if o_next!=0, else FETCH.
//   Redirect in IDLE: pc <= redirect_pc and buf_flush=1; the state stays IDLE.
//   Stale responses: the first drop_cnt responses after a redirect are stale.
//     Each one is dropped and returns its reserved credit.
//   FSM:
//     IDLE  -> FETCH when fetch_en=1.
//     FETCH -> IDLE  when fetch_en=0 and outstanding==0 (after this cycle's response).
//              With fetch_en=0 and outstanding!=0, the state stays FETCH; no issue, responses are written.
//     FETCH -> DRAIN on redirect with o_next!=0.
//     DRAIN: no issue. Responses are dropped.
//            -> FETCH when drop_cnt reaches 0.
//            A redirect in DRAIN reloads pc and drop_cnt using the rules above.
//   Full buffer: credits==0 stalls issue. Writes never exceed BUFFER_DEPTH entries, so the buffer
//     never sees a write while full.
// TESTING
//   1. Reset, then fetch_en=1, ready=1, responses at 1-cycle latency, no pops ->
//      exactly 8 requests at 0x0,0x4,...,0x1C; imem_req_valid=0 afterwards; 8 buf_wr_en pulses.
//   2. Continue test 1 with one buf_rd_en pulse -> exactly one further request, at 0x20.
//   3. Three requests outstanding, then redirect_pc=0x100 ->
//      buf_flush=1 for one cycle; state=DRAIN; the next 3 responses have buf_wr_en=0;
//      the next request address is 0x100; credits return to 8.
//   4. Redirect in the same cycle as a response with outstanding=1 ->
//      that response is dropped; state goes directly to FETCH; credits=8.
//   5. MAX_OUTSTANDING=4 with imem never responding -> exactly 4 requests, then valid=0;
//      a spurious resp_valid with outstanding=0 -> proto_err=1 until reset.
//   6. Assert reset mid-DRAIN -> all outputs clear immediately; the first request after
//      fetch_en is at RESET_PC.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer. It issues sequential fetch addresses to
// instruction memory and reserves one instruction-buffer slot per request,
// so every returning instruction has a free slot to land in. Responses are
// written into the buffer in the cycle they arrive. A redirect flushes the
// buffer, restarts at the new PC and drops responses that were still in
// flight for the old stream.
module fetch_controller #(
  parameter int                    INST_WIDTH      = 32,
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    BUFFER_DEPTH    = 8,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  output logic                  buf_wr_en,
  output logic [INST_WIDTH-1:0] buf_wr_data,
  input  logic                  buf_rd_en,
  output logic                  buf_flush,
  output logic                  busy,
  output logic                  proto_err
);

  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUFFER_DEPTH);
  localparam logic [OW-1:0] MAXO_C  = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_next;
  logic [CW-1:0]         r_credits, w_credits_next;
  logic [OW-1:0]         r_outstanding, w_out_next;
  logic [OW-1:0]         r_drop_cnt, w_drop_next;
  logic                  r_proto_err;

  logic                  w_resp_accept;
  logic [OW-1:0]         w_o_next;
  logic                  w_req_fire;
  logic                  w_wr;
  logic                  w_drop;

  // Request qualification and response classification for this cycle.
  always_comb begin
    // A response with nothing in flight is a protocol violation: ignore it.
    w_resp_accept  = imem_resp_valid && (r_outstanding != '0);
    // Outstanding count once this cycle's response has been retired.
    w_o_next       = r_outstanding - OW'(w_resp_accept);
    imem_req_valid = (r_state == S_FETCH) && fetch_en && !redirect_valid &&
                     (r_credits != '0) && (r_outstanding < MAXO_C);
    w_req_fire     = imem_req_valid && imem_req_ready;
    w_wr           = w_resp_accept && (r_drop_cnt == '0) && !redirect_valid;
    // A dropped response gives back the slot its request had reserved.
    w_drop         = w_resp_accept && !w_wr;
  end

  // Next-state for the FSM, PC and counters.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_credits_next = r_credits;
    w_out_next     = r_outstanding;
    w_drop_next    = r_drop_cnt;

    if (redirect_valid) begin
      // Everything still in flight belongs to the old stream: mark it stale
      // and keep its slots reserved until it comes back. The buffer is
      // flushed, so all other slots are free again.
      w_pc_next      = redirect_pc;
      w_out_next     = w_o_next;
      w_drop_next    = w_o_next;
      w_credits_next = DEPTH_C - CW'(w_o_next);
      if (r_state != S_IDLE) begin
        w_state_next = (w_o_next != '0) ? S_DRAIN : S_FETCH;
      end
    end else begin
      if (w_req_fire) begin
        w_pc_next = r_pc + ADDR_WIDTH'(4);
      end
      w_out_next     = w_o_next + OW'(w_req_fire);
      w_credits_next = r_credits - CW'(w_req_fire) + CW'(w_drop) + CW'(buf_rd_en);
      if (w_drop && (r_drop_cnt != '0)) begin
        w_drop_next = r_drop_cnt - OW'(1);
      end
      unique case (r_state)
        S_IDLE:  if (fetch_en) w_state_next = S_FETCH;
        S_FETCH: if (!fetch_en && (w_out_next == '0)) w_state_next = S_IDLE;
        S_DRAIN: if (w_drop_next == '0) w_state_next = S_FETCH;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // State, PC and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_credits     <= DEPTH_C;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_credits     <= w_credits_next;
      r_outstanding <= w_out_next;
      r_drop_cnt    <= w_drop_next;
    end
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_proto_err <= 1'b0;
    end else if (imem_resp_valid && (r_outstanding == '0)) begin
      r_proto_err <= 1'b1;
    end
  end

  assign imem_req_addr = r_pc;
  assign buf_wr_en     = w_wr;
  assign buf_wr_data   = imem_resp_data;
  assign buf_flush     = redirect_valid;
  assign busy          = (r_state != S_IDLE);
  assign proto_err     = r_proto_err;

endmodule
